// File: rtl/tcu_wmma_uop_sequencer.sv
// WMMA micro-op sequencer: expands one accepted WMMA instruction into
// M_STEPS*N_STEPS*K_STEPS block uops (k innermost, then n, then m).
module tcu_wmma_uop_sequencer #(
    parameter int unsigned M_STEPS = 4,
    parameter int unsigned N_STEPS = 2,
    parameter int unsigned K_STEPS = 2,
    parameter int unsigned RA_BASE = 0,
    parameter int unsigned RB_BASE = 28,
    parameter int unsigned RC_BASE = 10,
    parameter int unsigned WID_W   = 2,
    parameter int unsigned TAG_W   = 8,
    localparam int unsigned MW = (M_STEPS > 1) ? $clog2(M_STEPS) : 1,
    localparam int unsigned NW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
    localparam int unsigned KW = (K_STEPS > 1) ? $clog2(K_STEPS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WID_W-1:0] in_wid,
    input  logic [3:0]       in_fmt_s,
    input  logic [3:0]       in_fmt_d,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WID_W-1:0] out_wid,
    output logic [3:0]       out_fmt_s,
    output logic [3:0]       out_fmt_d,
    output logic [TAG_W-1:0] out_tag,
    output logic [MW-1:0]    out_step_m,
    output logic [NW-1:0]    out_step_n,
    output logic [KW-1:0]    out_step_k,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rs3,
    output logic             out_acc_first,
    output logic             out_acc_last,
    output logic             out_eop,
    output logic             busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    localparam int unsigned RS1_MAX = RA_BASE + M_STEPS * K_STEPS - 1;
    localparam int unsigned RS2_MAX = RB_BASE + N_STEPS * K_STEPS - 1;
    localparam int unsigned RS3_MAX = RC_BASE + M_STEPS * N_STEPS - 1;

    logic [0:0]       state_q, state_d;
    logic [MW-1:0]    m_d;
    logic [NW-1:0]    n_d;
    logic [KW-1:0]    k_d;
    logic [WID_W-1:0] wid_d;
    logic [3:0]       fmt_s_d, fmt_d_d;
    logic [TAG_W-1:0] tag_d;
    logic [4:0]       rs1_d, rs2_d, rs3_d;
    logic             first_d, last_d, eop_d;
    logic             k_last, n_last;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == ISSUE);
    assign busy      = (state_q == ISSUE);

    assign k_last = (out_step_k == KW'(K_STEPS - 1));
    assign n_last = (out_step_n == NW'(N_STEPS - 1));

    // Next state, step counters and the uop fields derived from them
    always_comb begin
        state_d = state_q;
        m_d     = out_step_m;
        n_d     = out_step_n;
        k_d     = out_step_k;
        wid_d   = out_wid;
        fmt_s_d = out_fmt_s;
        fmt_d_d = out_fmt_d;
        tag_d   = out_tag;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ISSUE;
                    wid_d   = in_wid;
                    fmt_s_d = in_fmt_s;
                    fmt_d_d = in_fmt_d;
                    tag_d   = in_tag;
                    m_d     = '0;
                    n_d     = '0;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    if (out_eop) begin
                        state_d = IDLE;
                    end else if (k_last) begin
                        k_d = '0;
                        if (n_last) begin
                            n_d = '0;
                            m_d = out_step_m + MW'(1);
                        end else begin
                            n_d = out_step_n + NW'(1);
                        end
                    end else begin
                        k_d = out_step_k + KW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rs1_d   = 5'(RA_BASE + 32'(m_d) * K_STEPS + 32'(k_d));
        rs2_d   = 5'(RB_BASE + 32'(n_d) * K_STEPS + 32'(k_d));
        rs3_d   = 5'(RC_BASE + 32'(m_d) * N_STEPS + 32'(n_d));
        first_d = (k_d == '0);
        last_d  = (k_d == KW'(K_STEPS - 1));
        eop_d   = (m_d == MW'(M_STEPS - 1)) && (n_d == NW'(N_STEPS - 1)) && last_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            out_step_m    <= '0;
            out_step_n    <= '0;
            out_step_k    <= '0;
            out_wid       <= '0;
            out_fmt_s     <= '0;
            out_fmt_d     <= '0;
            out_tag       <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rs3       <= '0;
            out_acc_first <= 1'b0;
            out_acc_last  <= 1'b0;
            out_eop       <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_step_m    <= m_d;
            out_step_n    <= n_d;
            out_step_k    <= k_d;
            out_wid       <= wid_d;
            out_fmt_s     <= fmt_s_d;
            out_fmt_d     <= fmt_d_d;
            out_tag       <= tag_d;
            out_rs1       <= rs1_d;
            out_rs2       <= rs2_d;
            out_rs3       <= rs3_d;
            out_acc_first <= first_d;
            out_acc_last  <= last_d;
            out_eop       <= eop_d;
        end
    end

    // Register indices must fit in 5 bits for the chosen tile geometry
    a_param_range: assert property (@(posedge clk) disable iff (reset)
        (RS1_MAX < 32) && (RS2_MAX < 32) && (RS3_MAX < 32));

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> out_valid && $stable({out_wid, out_fmt_s, out_fmt_d,
        out_tag, out_step_m, out_step_n, out_step_k, out_rs1, out_rs2, out_rs3,
        out_acc_first, out_acc_last, out_eop}));

    a_step_bounds: assert property (@(posedge clk) disable iff (reset)
        (32'(out_step_m) < M_STEPS) && (32'(out_step_n) < N_STEPS) && (32'(out_step_k) < K_STEPS));

endmodule

// File: tb/tb_tcu_wmma_uop_sequencer.sv
// Self-checking bench for tcu_wmma_uop_sequencer: randomized handshakes
// compared against a loop-nest reference model of the uop expansion.
module tb_tcu_wmma_uop_sequencer;

    localparam int unsigned M = 4, N = 2, K = 2, RA = 0, RB = 28, RC = 10;

    typedef struct packed {
        logic [1:0] m;
        logic [0:0] n;
        logic [0:0] k;
        logic [4:0] rs1, rs2, rs3;
        logic       first, last, eop;
        logic [1:0] wid;
        logic [3:0] fs, fd;
        logic [7:0] tag;
    } uop_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0] in_wid, out_wid;
    logic [3:0] in_fmt_s, in_fmt_d, out_fmt_s, out_fmt_d;
    logic [7:0] in_tag, out_tag;
    logic [1:0] out_step_m;
    logic [0:0] out_step_n, out_step_k;
    logic [4:0] out_rs1, out_rs2, out_rs3;
    logic       out_acc_first, out_acc_last, out_eop;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [1:0] out_wid1;
    logic [3:0] out_fmt_s1, out_fmt_d1;
    logic [7:0] out_tag1;
    logic [0:0] out_step_m1, out_step_n1, out_step_k1;
    logic [4:0] out_rs11, out_rs21, out_rs31;
    logic       out_acc_first1, out_acc_last1, out_eop1;

    tcu_wmma_uop_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid),
        .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
        .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d), .out_tag(out_tag),
        .out_step_m(out_step_m), .out_step_n(out_step_n), .out_step_k(out_step_k),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
        .out_acc_first(out_acc_first), .out_acc_last(out_acc_last),
        .out_eop(out_eop), .busy(busy)
    );

    tcu_wmma_uop_sequencer #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_wid(2'd1),
        .in_fmt_s(4'd9), .in_fmt_d(4'd8), .in_tag(8'hC3),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_wid(out_wid1),
        .out_fmt_s(out_fmt_s1), .out_fmt_d(out_fmt_d1), .out_tag(out_tag1),
        .out_step_m(out_step_m1), .out_step_n(out_step_n1), .out_step_k(out_step_k1),
        .out_rs1(out_rs11), .out_rs2(out_rs21), .out_rs3(out_rs31),
        .out_acc_first(out_acc_first1), .out_acc_last(out_acc_last1),
        .out_eop(out_eop1), .busy(busy1)
    );

    int   tests = 0, fails = 0;
    uop_t exp_q[$], got_q[$];
    int   stall_err, drain_cycles;
    bit   drain_timeout;

    // Reference model: plain loop nest over the tile, k innermost
    task automatic model_append(input logic [1:0] wid, input logic [3:0] fs, input logic [3:0] fd,
                                input logic [7:0] tag);
        uop_t u;
        for (int m = 0; m < int'(M); m++)
            for (int n = 0; n < int'(N); n++)
                for (int k = 0; k < int'(K); k++) begin
                    u.m = 2'(m); u.n = 1'(n); u.k = 1'(k);
                    u.rs1 = 5'(int'(RA) + m * int'(K) + k);
                    u.rs2 = 5'(int'(RB) + n * int'(K) + k);
                    u.rs3 = 5'(int'(RC) + m * int'(N) + n);
                    u.first = (k == 0);
                    u.last  = (k == int'(K) - 1);
                    u.eop   = (m == int'(M) - 1) && (n == int'(N) - 1) && (k == int'(K) - 1);
                    u.wid = wid; u.fs = fs; u.fd = fd; u.tag = tag;
                    exp_q.push_back(u);
                end
    endtask

    function automatic uop_t sample();
        uop_t u;
        u.m = out_step_m; u.n = out_step_n; u.k = out_step_k;
        u.rs1 = out_rs1; u.rs2 = out_rs2; u.rs3 = out_rs3;
        u.first = out_acc_first; u.last = out_acc_last; u.eop = out_eop;
        u.wid = out_wid; u.fs = out_fmt_s; u.fd = out_fmt_d; u.tag = out_tag;
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] wid, input logic [3:0] fs, input logic [3:0] fd,
                         input logic [7:0] tag, output bit ok);
        for (int i = 0; i < 100 && !in_ready; i++) step();
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1; in_wid = wid; in_fmt_s = fs; in_fmt_d = fd; in_tag = tag;
            step();
            in_valid = 1'b0;
        end
    endtask

    // Collect n handshaken uops, noting any field change across a stall
    task automatic drain(input int n, input int ready_pct, input int budget);
        uop_t cur, prev;
        bit   prev_stall = 1'b0;
        got_q.delete();
        stall_err = 0; drain_cycles = 0; drain_timeout = 1'b0;
        prev = '0;
        while (got_q.size() < n) begin
            if (drain_cycles >= budget) begin
                drain_timeout = 1'b1;
                break;
            end
            cur = sample();
            if (prev_stall && (!out_valid || cur !== prev)) stall_err++;
            out_ready = ($urandom_range(99) < 32'(ready_pct));
            if (out_valid && out_ready) got_q.push_back(cur);
            prev_stall = out_valid && !out_ready;
            prev = cur;
            step();
            drain_cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_wid = '0; in_fmt_s = '0; in_fmt_d = '0; in_tag = '0;
        out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
        repeat (3) step();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: valid=%b busy=%b in_ready=%b, required 0 0 0", out_valid, busy, in_ready);
        end
        tests++;
        if (sample() !== uop_t'(0)) begin
            fails++;
            $display("FAIL reset_fields: got %h, required 0", sample());
        end
        reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: in_ready=%b in_ready1=%b, required 1 1", in_ready, in_ready1);
        end
    endtask

    task automatic test_single();
        bit ok;
        out_ready = 1'b1;
        exp_q.delete();
        model_append(2'd2, 4'd1, 4'd0, 8'h5A);
        issue(2'd2, 4'd1, 4'd0, 8'h5A, ok);
        tests++;
        if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_latency: ok=%b valid=%b in_ready=%b, required 1 1 0", ok, out_valid, in_ready);
        end
        drain(16, 100, 100);
        tests++;
        if (drain_timeout || drain_cycles != 16) begin
            fails++;
            $display("FAIL single_throughput: cycles=%0d timeout=%b, required 16 0", drain_cycles, drain_timeout);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL single_uop%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() == 16) begin
            tests++;
            if (got_q[0].rs1 !== 5'd0 || got_q[0].rs2 !== 5'd28 || got_q[0].rs3 !== 5'd10 ||
                got_q[15].rs1 !== 5'd7 || got_q[15].rs2 !== 5'd31 || got_q[15].rs3 !== 5'd17) begin
                fails++;
                $display("FAIL single_regs: first %0d/%0d/%0d last %0d/%0d/%0d, required 0/28/10 7/31/17",
                         got_q[0].rs1, got_q[0].rs2, got_q[0].rs3, got_q[15].rs1, got_q[15].rs2, got_q[15].rs3);
            end
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done: in_ready=%b valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        logic [1:0] wid;
        logic [3:0] fs, fd;
        logic [7:0] tag;
        for (int r = 0; r < 3; r++) begin
            wid = 2'($urandom); fs = 4'($urandom); fd = 4'($urandom); tag = 8'($urandom);
            exp_q.delete();
            model_append(wid, fs, fd, tag);
            issue(wid, fs, fd, tag, ok);
            drain(16, 50, 600);
            tests++;
            if (!ok || drain_timeout || stall_err != 0 || got_q.size() != 16) begin
                fails++;
                $display("FAIL random_hold%0d: ok=%b timeout=%b stall_err=%0d n=%0d, required 1 0 0 16",
                         r, ok, drain_timeout, stall_err, got_q.size());
            end
            for (int i = 0; i < got_q.size(); i++) begin
                tests++;
                if (got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL random%0d_uop%0d: got %h, required %h", r, i, got_q[i], exp_q[i]);
                end
            end
            out_ready = 1'b0;
            step();
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL random_extra%0d: valid=%b in_ready=%b, required 0 1", r, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int eop1 = -1, acc2 = -1, cyc = 0;
        uop_t cur;
        out_ready = 1'b1;
        exp_q.delete();
        model_append(2'd1, 4'd2, 4'd0, 8'h01);
        model_append(2'd1, 4'd2, 4'd0, 8'h02);
        for (int i = 0; i < 100 && !in_ready; i++) step();
        in_valid = 1'b1; in_wid = 2'd1; in_fmt_s = 4'd2; in_fmt_d = 4'd0; in_tag = 8'h01;
        step();
        in_tag = 8'h02;
        got_q.delete();
        while (got_q.size() < 32 && cyc < 200) begin
            cur = sample();
            if (in_valid && in_ready && acc2 < 0) acc2 = cyc;
            if (out_valid && out_ready) begin
                got_q.push_back(cur);
                if (cur.eop && eop1 < 0) eop1 = cyc;
            end
            step();
            if (acc2 >= 0) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        tests++;
        if (eop1 != 15 || acc2 != eop1 + 1 || cyc != 33) begin
            fails++;
            $display("FAIL b2b_timing: eop1=%0d accept2=%0d cycles=%0d, required 15 16 33", eop1, acc2, cyc);
        end
        tests++;
        if (got_q.size() != 32) begin
            fails++;
            $display("FAIL b2b_count: got %0d uops, required 32", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL b2b_uop%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        issue(2'd3, 4'd9, 4'd8, 8'h33, ok);
        drain(5, 100, 50);
        reset = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sample() !== uop_t'(0)) begin
            fails++;
            $display("FAIL midreset_clear: valid=%b busy=%b fields=%h, required 0 0 0", out_valid, busy, sample());
        end
        step();
        reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_ready: in_ready=%b, required 1", in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_noissue: valid=%b, required 0", out_valid);
        end
        exp_q.delete();
        model_append(2'd0, 4'd11, 4'd8, 8'h44);
        issue(2'd0, 4'd11, 4'd8, 8'h44, ok);
        drain(16, 100, 100);
        tests++;
        if (!ok || drain_timeout || got_q.size() != 16) begin
            fails++;
            $display("FAIL midreset_restart: ok=%b timeout=%b n=%0d, required 1 0 16", ok, drain_timeout, got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL midreset_uop%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall10();
        bit ok;
        out_ready = 1'b0;
        exp_q.delete();
        model_append(2'd2, 4'd3, 4'd0, 8'h77);
        issue(2'd2, 4'd3, 4'd0, 8'h77, ok);
        for (int c = 0; c < 10; c++) begin
            tests++;
            if (!ok || out_valid !== 1'b1 || sample() !== exp_q[0]) begin
                fails++;
                $display("FAIL stall10_hold%0d: valid=%b got %h, required 1 %h", c, out_valid, sample(), exp_q[0]);
            end
            step();
        end
        drain(16, 100, 100);
        tests++;
        if (drain_timeout || drain_cycles != 16) begin
            fails++;
            $display("FAIL stall10_resume: cycles=%0d timeout=%b, required 16 0", drain_cycles, drain_timeout);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL stall10_uop%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_degenerate();
        out_ready1 = 1'b0;
        tests++;
        if (in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL degen_ready: in_ready1=%b, required 1", in_ready1);
        end
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        tests++;
        if (out_valid1 !== 1'b1 || out_rs11 !== 5'd0 || out_rs21 !== 5'd28 || out_rs31 !== 5'd10 ||
            out_acc_first1 !== 1'b1 || out_acc_last1 !== 1'b1 || out_eop1 !== 1'b1 || out_tag1 !== 8'hC3) begin
            fails++;
            $display("FAIL degen_uop: v=%b rs=%0d/%0d/%0d f/l/e=%b%b%b tag=%h, required 1 0/28/10 111 c3",
                     out_valid1, out_rs11, out_rs21, out_rs31, out_acc_first1, out_acc_last1, out_eop1, out_tag1);
        end
        out_ready1 = 1'b1;
        step();
        tests++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL degen_done: valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid1, in_ready1, busy1);
        end
        out_ready1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single();
        test_random_ready();
        test_back_to_back();
        test_reset_mid();
        test_stall10();
        test_degenerate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
